gate_sweep_tester: RTL and testbench

GATE_SWEEP_TESTER -- requirements
Module: gate_sweep_tester

---
 rtl/gate_sweep_tester.sv | 111 +++++++++++
 tb/tb_gate_sweep_tester.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_tester.sv
// ---------------------------------------------------------------------------
// gate_sweep_tester: exhaustive 64-vector sweep of a six-input AOI gate. Rev 1.0
// Optional first_fail capture with macro GATE_SWEEP_FIRST_FAIL_EN.
// ---------------------------------------------------------------------------
`default_nettype none

module gate_sweep_tester #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       y_in,
   output logic [5:0] vec,
   output logic       busy,
   output logic       done,
   output logic       pass,
`ifdef GATE_SWEEP_FIRST_FAIL_EN
   output logic [5:0] first_fail,
`endif
   output logic [6:0] err_count
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t     state;
   logic [3:0] settle_cnt;
   logic       expected_y;
   logic       mismatch;

   // Golden model: Y = NOT((A|B) & ((C&D) | (E&F)))
   always_comb begin
      expected_y = ~((vec[5] | vec[4]) & ((vec[3] & vec[2]) | (vec[1] & vec[0])));
      mismatch   = (y_in != expected_y);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         vec        <= 6'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= 7'd0;
         settle_cnt <= 4'd0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
         first_fail <= 6'd0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= SETTLE;
                  vec        <= 6'd0;
                  settle_cnt <= 4'd0;
                  err_count  <= 7'd0;
                  pass       <= 1'b0;
                  busy       <= 1'b1;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
                  first_fail <= 6'd0;
`endif
               end
            end
            SETTLE: begin
               settle_cnt <= settle_cnt + 4'd1;
               if (settle_cnt == SETTLE_LAST) begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               if (mismatch && (err_count != 7'd64)) begin
                  err_count <= err_count + 7'd1;
               end
`ifdef GATE_SWEEP_FIRST_FAIL_EN
               if (mismatch && (err_count == 7'd0)) begin
                  first_fail <= vec;
               end
`endif
               if (vec == 6'd63) begin
                  // Last vector: pass must account for a mismatch on this very edge
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  pass  <= (err_count == 7'd0) && !mismatch;
               end else begin
                  vec        <= vec + 6'd1;
                  settle_cnt <= 4'd0;
                  state      <= SETTLE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep_tester.sv
// ---------------------------------------------------------------------------
// tb_gate_sweep_tester: table-driven sweeps plus reset / held-start / SETTLE=1 cases. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gate_sweep_tester;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, start2, y_in, y2;
   logic [5:0] vec, vec2;
   logic       busy, done, pass, busy2, done2, pass2;
   logic [6:0] err_count, err2;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
   logic [5:0] first_fail, ff2;
`endif
   logic [2:0] mode;

   int checks = 0;
   int errors = 0;

   function automatic logic gate(input logic [5:0] v);
      return ~((v[5] | v[4]) & ((v[3] & v[2]) | (v[1] & v[0])));
   endfunction

   // Gate-under-test emulation: 0 correct, 1 stuck-0, 2 stuck-1, 3 wrong only at 40, 4 inverted
   always_comb begin
      y_in = gate(vec);
      case (mode)
         3'd1:    y_in = 1'b0;
         3'd2:    y_in = 1'b1;
         3'd3:    y_in = (vec == 6'd40) ? ~gate(vec) : gate(vec);
         3'd4:    y_in = ~gate(vec);
         default: y_in = gate(vec);
      endcase
      y2 = gate(vec2);
   end

   gate_sweep_tester dut (
      .clk(clk), .rst(rst), .start(start), .y_in(y_in), .vec(vec),
      .busy(busy), .done(done), .pass(pass),
`ifdef GATE_SWEEP_FIRST_FAIL_EN
      .first_fail(first_fail),
`endif
      .err_count(err_count)
   );

   gate_sweep_tester #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start2), .y_in(y2), .vec(vec2),
      .busy(busy2), .done(done2), .pass(pass2),
`ifdef GATE_SWEEP_FIRST_FAIL_EN
      .first_fail(ff2),
`endif
      .err_count(err2)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Start seen at cycle 0; returns the cycle in which done is observed (400 = timeout)
   task automatic run_sweep(output int cyc);
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0; cyc = 1;
      while (!done && cyc < 400) begin
         @(negedge clk); cyc++;
      end
   endtask

   typedef struct {
      logic [2:0] mode;
      int         exp_err;
      logic       exp_pass;
      logic [5:0] exp_ff;
   } sweep_vec_t;

   sweep_vec_t tbl[5];

   initial begin
      int cyc, dcount, bcount, first_done, second_done, err_at_second;

      tbl[0] = '{3'd0,  0, 1'b1, 6'd0};
      tbl[1] = '{3'd1, 43, 1'b0, 6'd0};
      tbl[2] = '{3'd2, 21, 1'b0, 6'd19};
      tbl[3] = '{3'd3,  1, 1'b0, 6'd40};
      tbl[4] = '{3'd4, 64, 1'b0, 6'd0};

      rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 3'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset vec", vec, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset pass", pass, 0);
      check("reset err_count", err_count, 0);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
      check("reset first_fail", first_fail, 0);
`endif
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle no start busy", busy, 0);

      for (int i = 0; i < 5; i++) begin
         mode = tbl[i].mode;
         run_sweep(cyc);
         check($sformatf("sweep%0d done cycle", i), cyc, 193);
         check($sformatf("sweep%0d err_count", i), err_count, tbl[i].exp_err);
         check($sformatf("sweep%0d pass", i), pass, tbl[i].exp_pass);
         check($sformatf("sweep%0d busy at done", i), busy, 0);
         check($sformatf("sweep%0d vec at done", i), vec, 63);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
         check($sformatf("sweep%0d first_fail", i), first_fail, tbl[i].exp_ff);
`endif
         @(negedge clk);
         check($sformatf("sweep%0d done one cycle", i), done, 0);
         check($sformatf("sweep%0d pass held", i), pass, tbl[i].exp_pass);
         check($sformatf("sweep%0d err held", i), err_count, tbl[i].exp_err);
      end

      // Reset at cycle 50 of a stuck-0 sweep: vectors 0..15 already sampled, all mismatching
      mode = 3'd1;
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0; cyc = 1;
      while (cyc < 50) begin
         @(negedge clk); cyc++;
      end
      check("mid-sweep busy", busy, 1);
      check("mid-sweep err_count", err_count, 16);
      check("mid-sweep vec", vec, 16);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check("post-rst vec", vec, 0);
      check("post-rst busy", busy, 0);
      check("post-rst err_count", err_count, 0);
      check("post-rst done", done, 0);
      dcount = 0; bcount = 0;
      for (int k = 0; k < 250; k++) begin
         @(negedge clk);
         if (done) dcount++;
         if (busy) bcount++;
      end
      check("post-rst no done", dcount, 0);
      check("post-rst no restart", bcount, 0);

      // rst wins over start in the same cycle
      @(negedge clk); rst = 1'b1; start = 1'b1;
      @(negedge clk); rst = 1'b0; start = 1'b0;
      check("rst over start busy", busy, 0);
      repeat (3) @(negedge clk);
      check("rst over start stays idle", busy, 0);

      // start held high across two sweeps
      mode = 3'd1;
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      @(negedge clk); cyc = 1;
      dcount = 0; first_done = 0; second_done = 0; err_at_second = -1;
      while (cyc <= 390) begin
         if (done) begin
            dcount++;
            if (first_done == 0) first_done = cyc;
            else begin
               second_done = cyc;
               err_at_second = err_count;
            end
         end
         if (cyc == 195) begin
            check("held start restart busy", busy, 1);
            check("held start err recleared", err_count, 0);
         end
         if (cyc == 387) start = 1'b0;
         @(negedge clk); cyc++;
      end
      check("held start done count", dcount, 2);
      check("held start first done", first_done, 193);
      check("held start second done", second_done, 387);
      check("held start second err", err_at_second, 43);
      check("held start idle after", busy, 0);

      // SETTLE_CYCLES = 1 instance
      @(negedge clk); start2 = 1'b1;
      @(posedge clk);
      @(negedge clk); start2 = 1'b0; cyc = 1;
      while (!done2 && cyc < 400) begin
         @(negedge clk); cyc++;
      end
      check("settle1 done cycle", cyc, 129);
      check("settle1 pass", pass2, 1);
      check("settle1 err_count", err2, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
